// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for a parallel-in / serial-out shift register.
// A WIDTH-bit word is accepted over a valid/ready handshake and loaded into an
// internal shift register. It is then emitted as SHIFT_AMOUNT-bit beats, with
// one shift per accepted output beat. A one-cycle done pulse follows the
// final beat. Backpressure on the output side stalls the register. An abort
// in the SHIFT state drops the current word without issuing done.
//
// Parameters:
//   WIDTH           - width of the loaded word / shift register (>= 2)
//   SHIFT_AMOUNT    - bits per output beat (1..5, <= WIDTH)
//   SHIFT_DIRECTION - "LEFT"  : MSB-first, shift left
//                     "RIGHT" : LSB-first, shift right
//                     any other value behaves as "LEFT"
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst        in   synchronous active-low reset
//   in_valid   in   producer has a word on in_data
//   in_data    in   word to load (WIDTH bits)
//   in_ready   out  controller can accept a word (IDLE and not in reset)
//   out_valid  out  out_data holds a valid beat (SHIFT state)
//   out_data   out  current beat (SHIFT_AMOUNT bits)
//   out_ready  in   consumer accepts the beat
//   abort      in   cancel the current word (honoured only in SHIFT)
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse after the final beat is accepted
// ----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SHIFT_AMOUNT    = 1,
    parameter string       SHIFT_DIRECTION = "LEFT"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [SHIFT_AMOUNT-1:0] out_data,
    input  logic                    out_ready,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned     BEATS     = (WIDTH + SHIFT_AMOUNT - 1) / SHIFT_AMOUNT;
    localparam int unsigned     CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Anything other than an exact "RIGHT" falls back to MSB-first operation.
    localparam bit              DIR_RIGHT = (SHIFT_DIRECTION == "RIGHT");

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sreg_shifted;

    // Direction-dependent beat extraction and zero-filled shift.
    if (DIR_RIGHT) begin : g_right
        assign out_data     = sreg_q[SHIFT_AMOUNT-1:0];
        assign sreg_shifted = sreg_q >> SHIFT_AMOUNT;
    end else begin : g_left
        assign out_data     = sreg_q[WIDTH-1 -: SHIFT_AMOUNT];
        assign sreg_shifted = sreg_q << SHIFT_AMOUNT;
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Abort wins over a simultaneous output handshake: the beat
                // on out_data is dropped, not consumed.
                if (abort) begin
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    sreg_d = sreg_shifted;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    assign in_ready  = (state_q == ST_IDLE) && rst;
    assign out_valid = (state_q == ST_SHIFT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    logic clk;
    logic rst;

    // Instance A: WIDTH=8, SHIFT_AMOUNT=1, LEFT
    logic       a_in_valid;
    logic [7:0] a_in_data;
    logic       a_in_ready;
    logic       a_out_valid;
    logic [0:0] a_out_data;
    logic       a_out_ready;
    logic       a_abort;
    logic       a_busy;
    logic       a_done;

    // Instance B: WIDTH=8, SHIFT_AMOUNT=3, RIGHT
    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [2:0] b_out_data;
    logic       b_out_ready;
    logic       b_abort;
    logic       b_busy;
    logic       b_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] qa[$];
    logic [2:0] qb[$];

    shift_seq_ctrl #(
        .WIDTH(8),
        .SHIFT_AMOUNT(1),
        .SHIFT_DIRECTION("LEFT")
    ) u_a (
        .clk(clk),
        .rst(rst),
        .in_valid(a_in_valid),
        .in_data(a_in_data),
        .in_ready(a_in_ready),
        .out_valid(a_out_valid),
        .out_data(a_out_data),
        .out_ready(a_out_ready),
        .abort(a_abort),
        .busy(a_busy),
        .done(a_done)
    );

    shift_seq_ctrl #(
        .WIDTH(8),
        .SHIFT_AMOUNT(3),
        .SHIFT_DIRECTION("RIGHT")
    ) u_b (
        .clk(clk),
        .rst(rst),
        .in_valid(b_in_valid),
        .in_data(b_in_data),
        .in_ready(b_in_ready),
        .out_valid(b_out_valid),
        .out_data(b_out_data),
        .out_ready(b_out_ready),
        .abort(b_abort),
        .busy(b_busy),
        .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for A: MSB-first single bits.
    always @(negedge clk) begin
        if (rst) begin
            if (a_in_valid && a_in_ready) begin
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] t;
                    t = a_in_data >> (7 - i);
                    qa.push_back(t[0]);
                end
            end
            if (a_out_valid && a_out_ready && !a_abort) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_beat: unexpected beat %0b, scoreboard empty", a_out_data);
                end else begin
                    logic [0:0] e;
                    e = qa.pop_front();
                    if (a_out_data !== e) begin
                        n_fail++;
                        $display("FAIL a_beat: got %0b expected %0b", a_out_data, e);
                    end
                end
            end
        end
    end

    // Scoreboard for B: LSB-first 3-bit groups, zero-filled past bit 7.
    always @(negedge clk) begin
        if (rst) begin
            if (b_in_valid && b_in_ready) begin
                for (int i = 0; i < 3; i++) begin
                    logic [7:0] t;
                    t = b_in_data >> (3 * i);
                    qb.push_back(t[2:0]);
                end
            end
            if (b_out_valid && b_out_ready && !b_abort) begin
                n_checks++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_beat: unexpected beat %03b, scoreboard empty", b_out_data);
                end else begin
                    logic [2:0] e;
                    e = qb.pop_front();
                    if (b_out_data !== e) begin
                        n_fail++;
                        $display("FAIL b_beat: got %03b expected %03b", b_out_data, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_abort = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_abort = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({a_in_ready, a_out_valid, a_busy, a_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_a: rdy/vld/busy/done=%04b expected 0000",
                     {a_in_ready, a_out_valid, a_busy, a_done});
        end
        n_checks++;
        if ({b_in_ready, b_out_valid, b_busy, b_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_b: rdy/vld/busy/done=%04b expected 0000",
                     {b_in_ready, b_out_valid, b_busy, b_done});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready a=%0b b=%0b expected 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_left_s1();
        a_out_ready = 1'b1;
        a_in_data   = 8'hA5;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_done !== 1'b0) begin
                n_fail++;
                $display("FAIL left_beat_%0d: valid=%0b done=%0b expected 1/0", i, a_out_valid, a_done);
            end
            tick();
        end
        n_checks++;
        if ({a_done, a_busy, a_in_ready, a_out_valid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL left_done: done/busy/rdy/vld=%04b expected 1100",
                     {a_done, a_busy, a_in_ready, a_out_valid});
        end
        tick();
        n_checks++;
        if ({a_done, a_busy, a_in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL left_idle: done/busy/rdy=%03b expected 001", {a_done, a_busy, a_in_ready});
        end
        n_checks++;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL left_drain: %0d beats outstanding, expected 0", qa.size());
        end
    endtask

    task automatic test_right_s3();
        b_out_ready = 1'b1;
        b_in_data   = 8'hA5;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (b_out_valid !== 1'b1 || b_done !== 1'b0) begin
                n_fail++;
                $display("FAIL right_beat_%0d: valid=%0b done=%0b expected 1/0", i, b_out_valid, b_done);
            end
            tick();
        end
        n_checks++;
        if ({b_done, b_out_valid, b_in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL right_done: done/vld/rdy=%03b expected 100", {b_done, b_out_valid, b_in_ready});
        end
        tick();
        n_checks++;
        if (b_in_ready !== 1'b1 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL right_idle: in_ready=%0b outstanding=%0d expected 1/0", b_in_ready, qb.size());
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_stall();
        a_out_ready = 1'b0;
        a_in_data   = 8'hF0;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({a_out_valid, a_out_data, a_busy, a_done} !== 4'b1110) begin
                n_fail++;
                $display("FAIL stall_%0d: vld/data/busy/done=%04b expected 1110",
                         i, {a_out_valid, a_out_data, a_busy, a_done});
            end
            tick();
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_beat_%0d: valid=%0b expected 1", i, a_out_valid);
            end
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL stall_done: done=%0b outstanding=%0d expected 1/0", a_done, qa.size());
        end
        tick();
    endtask

    task automatic test_abort();
        a_out_ready = 1'b1;
        a_in_data   = 8'h3C;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        tick();
        // Fourth beat of 0x3C is 1; abort arrives with out_ready high.
        a_abort = 1'b1;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: valid=%0b data=%0b expected 1/1", a_out_valid, a_out_data);
        end
        tick();
        a_abort = 1'b0;
        n_checks++;
        if ({a_in_ready, a_out_valid, a_busy, a_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL abort_idle: rdy/vld/busy/done=%04b expected 1000",
                     {a_in_ready, a_out_valid, a_busy, a_done});
        end
        qa.delete();
        a_in_data  = 8'h81;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_reload_%0d: valid=%0b done=%0b expected 1/0", i, a_out_valid, a_done);
            end
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL abort_reload_done: done=%0b outstanding=%0d expected 1/0", a_done, qa.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b1;
        a_in_data   = 8'hC3;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_rdy_low: in_ready=%0b expected 0", a_in_ready);
        end
        tick();
        n_checks++;
        if ({a_out_valid, a_done, a_busy, a_in_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_state: vld/done/busy/rdy=%04b expected 0000",
                     {a_out_valid, a_done, a_busy, a_in_ready});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_release: in_ready=%0b expected 1", a_in_ready);
        end
        qa.delete();
        tick();
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done=%0b busy=%0b expected 0/0", a_done, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        a_in_data   = 8'h01;
        a_in_valid  = 1'b1;
        tick();
        a_in_data = 8'h80;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_w1_%0d: valid=%0b in_ready=%0b expected 1/0", i, a_out_valid, a_in_ready);
            end
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap_done: done=%0b in_ready=%0b expected 1/0", a_done, a_in_ready);
        end
        tick();
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap_idle: in_ready=%0b valid=%0b expected 1/0", a_in_ready, a_out_valid);
        end
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_w2_%0d: valid=%0b done=%0b expected 1/0", i, a_out_valid, a_done);
            end
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%0b outstanding=%0d expected 1/0", a_done, qa.size());
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_left_s1();
        test_right_s3();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencing controller for the parameterized parallel shift register datapath.
- Accepts a parallel word over a valid/ready handshake, loads it into an internal shift register, then emits it as SHIFT_AMOUNT-bit beats, one shift per accepted output beat.
- Pulses done after the last beat.
- Sits between a parallel producer and a narrow serial consumer; supports backpressure and abort.

Parameters:
- WIDTH, 8, width of loaded word / shift register (>= 2).
- SHIFT_AMOUNT, 1, bits shifted per beat; legal 1..5, must be <= WIDTH.
- SHIFT_DIRECTION, "LEFT", "LEFT" = MSB-first, shift left; "RIGHT" = LSB-first, shift right.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  WIDTH  word to load.
- in_ready  out  1  controller can accept a word.
- out_valid  out  1  out_data holds a valid beat.
- out_data  out  SHIFT_AMOUNT  current beat.
- out_ready  in  1  consumer accepts the beat.
- abort  in  1  cancel the current word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- BEATS = ceil(WIDTH/SHIFT_AMOUNT). Beat counter width is clog2(BEATS), minimum 1.
- Reset (rst==0 at an edge):
  - state = IDLE; shift register, counter, done, out_valid = 0.
  - in_ready = 0 while rst is low.
  - Reset overrides everything, including mid-word operation. A partial word is discarded and no done is issued.
- in_ready is 1 only in IDLE with rst high. out_valid is 1 only in SHIFT. Both are decoded from state.
- IDLE:
  - in_valid & in_ready: shift register <= in_data, counter <= 0, next state SHIFT.
  - The first beat is valid the following cycle, so load-to-first-beat latency is 1 cycle.
- SHIFT:
  - out_data for "LEFT" is sreg[WIDTH-1 -: SHIFT_AMOUNT].
  - out_data for "RIGHT" is sreg[SHIFT_AMOUNT-1:0].
  - On out_valid & out_ready, the register shifts by SHIFT_AMOUNT in the configured direction, with zero fill.
    - If counter == BEATS-1: next state DONE.
    - Otherwise: counter + 1.
  - out_ready low: register, counter and out_data hold (stall, no shift).
  - When WIDTH is not a multiple of SHIFT_AMOUNT, the final beat carries zero-filled bits in its trailing positions.
- DONE:
  - done = 1, busy = 1, in_ready = 0 for exactly one cycle; then IDLE.
  - Back-to-back words therefore have a 2-cycle gap: the DONE cycle, then the IDLE accept cycle.
- abort:
  - Sampled only in SHIFT. It has priority over a simultaneous out handshake.
  - That beat is NOT consumed. Shift register and counter clear to 0, next state IDLE, done is not asserted.
  - abort in IDLE or DONE is ignored.
- in_valid outside IDLE is ignored; in_data is not sampled.
- The shift register is never shifted outside SHIFT; it holds its value in DONE/IDLE until the next load.
- An illegal SHIFT_DIRECTION value behaves as "LEFT".

Test Plan:
- WIDTH=8, S=1, LEFT; load 0xA5 with out_ready=1 -> out_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; done high the cycle after the 8th beat; in_ready back high the cycle after that.
- WIDTH=8, S=3, RIGHT; load 0xA5 -> 3 beats: 3'b101, 3'b100, 3'b010 (zero-filled); done after the 3rd beat.
- S=1, LEFT, load 0xF0; hold out_ready=0 for 5 cycles after the first beat appears -> out_data stays 1, counter does not advance, busy=1; sequence then completes with 8 total beats.
- Load 0x3C, accept 3 beats, then assert abort together with out_ready=1 -> no shift on that edge, next cycle IDLE with in_ready=1, done never pulses; a following load of 0x81 streams 1,0,0,0,0,0,0,1.
- Mid-word (after 4 beats), drive rst=0 for 1 cycle -> next cycle state IDLE, out_valid=0, done=0, in_ready=0 during reset and 1 after release.
- Back-to-back: in_valid held high with 0x01 then 0x80 -> second word accepted exactly 2 cycles after the first word's final beat; both streams correct and in order.
